pipelined_controller: RTL and testbench

Registered successor to the combinational main controller. It decodes the ID-stage opcode into the same control signal set and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards with a parametrised memory latency, issues stalls and bubbles, and flushes on jumps and taken branches. It sits beside the datapath pipeline registers and replaces the per-stage control wiring.

---
 rtl/pipelined_controller.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_pipelined_controller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_controller.sv
// Pipelined main controller: ID-stage decode, control bundle carried through
// ID/EX, EX/MEM and MEM/WB, load-use stall FSM and branch/jump flush generation.

package pipelined_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic [1:0] reg_dst;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       branch_beq;
    logic       branch_bne;
    logic       jump;
  } ex_ctrl_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;
  } mem_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] reg_write_src;
  } wb_ctrl_t;

  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

endpackage

module pipelined_controller
  import pipelined_controller_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned RA_W    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [5:0]      id_opcode,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic [RA_W-1:0] id_rd,
  input  logic            ex_branch_taken,
  output logic            stall,
  output logic            if_flush,
  output logic [1:0]      ex_RegDst,
  output logic            ex_ALUSrc,
  output logic [2:0]      ex_ALUOp,
  output logic            ex_BranchBEQ,
  output logic            ex_BranchBNE,
  output logic            ex_Jump,
  output logic            mem_MemRead,
  output logic            mem_MemWrite,
  output logic [1:0]      mem_size,
  output logic            wb_RegWrite,
  output logic            wb_MemtoReg,
  output logic [1:0]      wb_RegWriteSrc,
  output logic [RA_W-1:0] wb_dst,
  output logic            illegal_op
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [RA_W-1:0] RA_LINK = RA_W'(31);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  ctrl_t           idex_q, idex_d;
  logic [RA_W-1:0] idex_dst_q, idex_dst_d;
  mem_ctrl_t       exmem_mem_q;
  wb_ctrl_t        exmem_wb_q;
  logic [RA_W-1:0] exmem_dst_q;
  wb_ctrl_t        memwb_wb_q;
  logic [RA_W-1:0] memwb_dst_q;
  logic            illegal_q, illegal_d;

  ctrl_t           dec_c;
  ctrl_t           dec_fix_c;
  logic            legal_c;
  logic            rs_used_c;
  logic            rt_used_c;
  logic [RA_W-1:0] dst_raw_c;
  logic [RA_W-1:0] dst_c;
  logic            ex_load_hit_c;
  logic            mem_load_hit_c;
  logic            hazard_c;
  logic            stall_c;
  logic            bubble_c;

  // Opcode decode into the control bundle plus source-register usage
  always_comb begin
    dec_c     = CTRL_BUBBLE;
    legal_c   = 1'b1;
    rs_used_c = 1'b0;
    rt_used_c = 1'b0;
    case (id_opcode)
      OP_RTYPE: begin
        dec_c.ex.reg_dst   = 2'd1;
        dec_c.ex.alu_op    = 3'd2;
        dec_c.wb.reg_write = 1'b1;
        rs_used_c          = 1'b1;
        rt_used_c          = 1'b1;
      end
      OP_J: begin
        dec_c.ex.jump = 1'b1;
      end
      OP_JAL: begin
        dec_c.ex.jump          = 1'b1;
        dec_c.ex.reg_dst       = 2'd2;
        dec_c.wb.reg_write_src = 2'd1;
        dec_c.wb.reg_write     = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec_c.ex.alu_op     = 3'd1;
        dec_c.ex.branch_beq = (id_opcode == OP_BEQ);
        dec_c.ex.branch_bne = (id_opcode == OP_BNE);
        rs_used_c           = 1'b1;
        rt_used_c           = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        dec_c.ex.alu_src   = 1'b1;
        dec_c.wb.reg_write = 1'b1;
        rs_used_c          = 1'b1;
        case (id_opcode)
          OP_SLTI:  dec_c.ex.alu_op = 3'd6;
          OP_SLTIU: dec_c.ex.alu_op = 3'd7;
          OP_ANDI:  dec_c.ex.alu_op = 3'd3;
          OP_ORI:   dec_c.ex.alu_op = 3'd4;
          OP_XORI:  dec_c.ex.alu_op = 3'd5;
          default:  dec_c.ex.alu_op = 3'd0;
        endcase
      end
      OP_LUI: begin
        dec_c.wb.reg_write_src = 2'd2;
        dec_c.wb.reg_write     = 1'b1;
      end
      OP_LW, OP_LHU, OP_LBU: begin
        dec_c.ex.alu_src    = 1'b1;
        dec_c.mem.mem_read  = 1'b1;
        dec_c.wb.mem_to_reg = 1'b1;
        dec_c.wb.reg_write  = 1'b1;
        rs_used_c           = 1'b1;
        case (id_opcode)
          OP_LHU:  dec_c.mem.mem_size = 2'd1;
          OP_LBU:  dec_c.mem.mem_size = 2'd2;
          default: dec_c.mem.mem_size = 2'd0;
        endcase
      end
      OP_SW, OP_SH, OP_SB: begin
        dec_c.ex.alu_src    = 1'b1;
        dec_c.mem.mem_write = 1'b1;
        rs_used_c           = 1'b1;
        rt_used_c           = 1'b1;
        case (id_opcode)
          OP_SH:   dec_c.mem.mem_size = 2'd1;
          OP_SB:   dec_c.mem.mem_size = 2'd2;
          default: dec_c.mem.mem_size = 2'd0;
        endcase
      end
      default: begin
        legal_c = 1'b0;
      end
    endcase
  end

  // Destination resolution; a write to $0 is dropped entirely
  always_comb begin
    case (dec_c.ex.reg_dst)
      2'd1:    dst_raw_c = id_rd;
      2'd2:    dst_raw_c = RA_LINK;
      default: dst_raw_c = id_rt;
    endcase
    dst_c     = dec_c.wb.reg_write ? dst_raw_c : '0;
    dec_fix_c = dec_c;
    if (dst_c == '0) begin
      dec_fix_c.wb.reg_write = 1'b0;
    end
  end

  // A load still in MEM only matters while its remaining wait count is nonzero
  always_comb begin
    ex_load_hit_c  = idex_q.mem.mem_read && (idex_dst_q != '0) &&
                     ((rs_used_c && (id_rs == idex_dst_q)) ||
                      (rt_used_c && (id_rt == idex_dst_q)));
    mem_load_hit_c = exmem_mem_q.mem_read && (exmem_dst_q != '0) &&
                     (state_q == ST_STALL) && (cnt_q != '0) &&
                     ((rs_used_c && (id_rs == exmem_dst_q)) ||
                      (rt_used_c && (id_rt == exmem_dst_q)));
    hazard_c       = id_valid && (ex_load_hit_c || mem_load_hit_c);
  end

  // Stall FSM next-state; a taken branch overrides any pending stall
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    if (ex_branch_taken) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hazard_c) begin
            stall_c = 1'b1;
            if (MEM_LAT > 1) begin
              state_d = ST_STALL;
              cnt_d   = CNT_W'(MEM_LAT - 1);
            end
          end
        end
        ST_STALL: begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    bubble_c   = ex_branch_taken || stall_c || !id_valid;
    idex_d     = bubble_c ? CTRL_BUBBLE : dec_fix_c;
    idex_dst_d = bubble_c ? '0 : dst_c;
    illegal_d  = illegal_q || (id_valid && !legal_c);
  end

  assign stall    = rst_n && stall_c;
  assign if_flush = rst_n && (ex_branch_taken ||
                              (id_valid && dec_c.ex.jump && !stall_c));

  // Pipeline registers, FSM state and sticky illegal flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      idex_q      <= CTRL_BUBBLE;
      idex_dst_q  <= '0;
      exmem_mem_q <= '0;
      exmem_wb_q  <= '0;
      exmem_dst_q <= '0;
      memwb_wb_q  <= '0;
      memwb_dst_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idex_q      <= idex_d;
      idex_dst_q  <= idex_dst_d;
      exmem_mem_q <= idex_q.mem;
      exmem_wb_q  <= idex_q.wb;
      exmem_dst_q <= idex_dst_q;
      memwb_wb_q  <= exmem_wb_q;
      memwb_dst_q <= exmem_dst_q;
      illegal_q   <= illegal_d;
    end
  end

  assign ex_RegDst      = idex_q.ex.reg_dst;
  assign ex_ALUSrc      = idex_q.ex.alu_src;
  assign ex_ALUOp       = idex_q.ex.alu_op;
  assign ex_BranchBEQ   = idex_q.ex.branch_beq;
  assign ex_BranchBNE   = idex_q.ex.branch_bne;
  assign ex_Jump        = idex_q.ex.jump;
  assign mem_MemRead    = exmem_mem_q.mem_read;
  assign mem_MemWrite   = exmem_mem_q.mem_write;
  assign mem_size       = exmem_mem_q.mem_size;
  assign wb_RegWrite    = memwb_wb_q.reg_write;
  assign wb_MemtoReg    = memwb_wb_q.mem_to_reg;
  assign wb_RegWriteSrc = memwb_wb_q.reg_write_src;
  assign wb_dst         = memwb_dst_q;
  assign illegal_op     = illegal_q;

endmodule

// File: tb/tb_pipelined_controller.sv
// Directed bench for pipelined_controller: one instance with MEM_LAT=1 (a_*)
// and one with MEM_LAT=3 (c_*), sharing inputs, each reset between scenarios.

module tb_pipelined_controller;

  localparam logic [5:0] T_RT  = 6'h00;
  localparam logic [5:0] T_JAL = 6'h03;
  localparam logic [5:0] T_LW  = 6'h23;

  localparam logic [8:0] EX_RT  = 9'b01_0_010_000;
  localparam logic [8:0] EX_JAL = 9'b10_0_000_001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       id_valid;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       ex_branch_taken;

  logic       a_stall, a_if_flush, a_ALUSrc, a_BEQ, a_BNE, a_Jump;
  logic       a_MemRead, a_MemWrite, a_RegWrite, a_MemtoReg, a_illegal;
  logic [1:0] a_RegDst, a_size, a_RWS;
  logic [2:0] a_ALUOp;
  logic [4:0] a_dst;

  logic       c_stall, c_if_flush, c_ALUSrc, c_BEQ, c_BNE, c_Jump;
  logic       c_MemRead, c_MemWrite, c_RegWrite, c_MemtoReg, c_illegal;
  logic [1:0] c_RegDst, c_size, c_RWS;
  logic [2:0] c_ALUOp;
  logic [4:0] c_dst;

  pipelined_controller #(.MEM_LAT(1), .RA_W(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
    .stall(a_stall), .if_flush(a_if_flush), .ex_RegDst(a_RegDst), .ex_ALUSrc(a_ALUSrc),
    .ex_ALUOp(a_ALUOp), .ex_BranchBEQ(a_BEQ), .ex_BranchBNE(a_BNE), .ex_Jump(a_Jump),
    .mem_MemRead(a_MemRead), .mem_MemWrite(a_MemWrite), .mem_size(a_size),
    .wb_RegWrite(a_RegWrite), .wb_MemtoReg(a_MemtoReg), .wb_RegWriteSrc(a_RWS),
    .wb_dst(a_dst), .illegal_op(a_illegal)
  );

  pipelined_controller #(.MEM_LAT(3), .RA_W(5)) dut_c (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
    .stall(c_stall), .if_flush(c_if_flush), .ex_RegDst(c_RegDst), .ex_ALUSrc(c_ALUSrc),
    .ex_ALUOp(c_ALUOp), .ex_BranchBEQ(c_BEQ), .ex_BranchBNE(c_BNE), .ex_Jump(c_Jump),
    .mem_MemRead(c_MemRead), .mem_MemWrite(c_MemWrite), .mem_size(c_size),
    .wb_RegWrite(c_RegWrite), .wb_MemtoReg(c_MemtoReg), .wb_RegWriteSrc(c_RWS),
    .wb_dst(c_dst), .illegal_op(c_illegal)
  );

  logic [8:0] a_ex, c_ex;
  logic [3:0] a_mem, c_mem, a_wb, c_wb;
  assign a_ex  = {a_RegDst, a_ALUSrc, a_ALUOp, a_BEQ, a_BNE, a_Jump};
  assign c_ex  = {c_RegDst, c_ALUSrc, c_ALUOp, c_BEQ, c_BNE, c_Jump};
  assign a_mem = {a_MemRead, a_MemWrite, a_size};
  assign c_mem = {c_MemRead, c_MemWrite, c_size};
  assign a_wb  = {a_RegWrite, a_MemtoReg, a_RWS};
  assign c_wb  = {c_RegWrite, c_MemtoReg, c_RWS};

  logic [5:0] ops     [20];
  logic [8:0] exp_ex  [20];
  logic [3:0] exp_mem [20];
  logic [3:0] exp_wb  [20];
  logic [4:0] exp_dst [20];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int idx, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic br);
    id_valid        = v;
    id_opcode       = op;
    id_rs           = rs;
    id_rt           = rt;
    id_rd           = rd;
    ex_branch_taken = br;
    #1;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    nxt();
    rst_n = 1'b1;
  endtask

  initial begin
    // opcode order: R j jal beq bne addi addiu slti sltiu andi ori xori lui lw lhu lbu sw sh sb undefined
    ops     = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h25, 6'h24, 6'h2B, 6'h29, 6'h28, 6'h3F};
    exp_ex  = '{9'b01_0_010_000, 9'b00_0_000_001, 9'b10_0_000_001, 9'b00_0_001_100,
                9'b00_0_001_010, 9'b00_1_000_000, 9'b00_1_000_000, 9'b00_1_110_000,
                9'b00_1_111_000, 9'b00_1_011_000, 9'b00_1_100_000, 9'b00_1_101_000,
                9'b00_0_000_000, 9'b00_1_000_000, 9'b00_1_000_000, 9'b00_1_000_000,
                9'b00_1_000_000, 9'b00_1_000_000, 9'b00_1_000_000, 9'b00_0_000_000};
    exp_mem = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1001, 4'b1010,
                4'b0100, 4'b0101, 4'b0110, 4'b0000};
    exp_wb  = '{4'b1000, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b1000,
                4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1010, 4'b1100, 4'b1100, 4'b1100,
                4'b0000, 4'b0000, 4'b0000, 4'b0000};
    // rt of step i is i+4 and rd is 3 in the sweep
    exp_dst = '{5'd3, 5'd0, 5'd31, 5'd0, 5'd0, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13,
                5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19, 5'd0, 5'd0, 5'd0, 5'd0};

    // Reset state, including combinational outputs forced low under reset
    rst_n = 1'b0;
    drive(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    nxt();
    nxt();
    chk("rst_ex_a", 0, 32'(a_ex), 32'd0);
    chk("rst_mem_a", 0, 32'(a_mem), 32'd0);
    chk("rst_wb_a", 0, 32'(a_wb), 32'd0);
    chk("rst_dst_c", 0, 32'(c_dst), 32'd0);
    chk("rst_ill_a", 0, 32'(a_illegal), 32'd0);
    drive(1'b1, 6'h02, 5'd0, 5'd0, 5'd0, 1'b1);
    chk("rst_flush_a", 0, 32'(a_if_flush), 32'd0);
    chk("rst_flush_c", 0, 32'(c_if_flush), 32'd0);
    chk("rst_stall_a", 0, 32'(a_stall), 32'd0);
    nxt();
    chk("rst_hold_ex_a", 0, 32'(a_ex), 32'd0);
    rst_n = 1'b1;

    // Opcode sweep, independent registers so no hazard arises
    for (int i = 0; i < 24; i++) begin
      if (i < 20) drive(1'b1, ops[i], 5'd1, 5'(i + 4), 5'd3, 1'b0);
      else        drive(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
      if (i >= 1 && i <= 20) begin
        chk("sw_ex_a", i - 1, 32'(a_ex), 32'(exp_ex[i-1]));
        chk("sw_ex_c", i - 1, 32'(c_ex), 32'(exp_ex[i-1]));
      end
      if (i >= 2 && i <= 21) begin
        chk("sw_mem_a", i - 2, 32'(a_mem), 32'(exp_mem[i-2]));
        chk("sw_mem_c", i - 2, 32'(c_mem), 32'(exp_mem[i-2]));
      end
      if (i >= 3 && i <= 22) begin
        chk("sw_wb_a", i - 3, 32'(a_wb), 32'(exp_wb[i-3]));
        chk("sw_dst_a", i - 3, 32'(a_dst), 32'(exp_dst[i-3]));
        chk("sw_wb_c", i - 3, 32'(c_wb), 32'(exp_wb[i-3]));
        chk("sw_dst_c", i - 3, 32'(c_dst), 32'(exp_dst[i-3]));
      end
      chk("sw_ill_a", i, 32'(a_illegal), 32'(i >= 20));
      chk("sw_ill_c", i, 32'(c_illegal), 32'(i >= 20));
      chk("sw_flush_a", i, 32'(a_if_flush), 32'((i == 1) || (i == 2)));
      chk("sw_stall_a", i, 32'(a_stall), 32'd0);
      nxt();
    end
    do_reset();
    chk("ill_clear_a", 0, 32'(a_illegal), 32'd0);
    chk("ill_clear_c", 0, 32'(c_illegal), 32'd0);

    // Load-use with MEM_LAT=1: one stall cycle, then the consumer proceeds
    drive(1'b1, T_LW, 5'd1, 5'd8, 5'd0, 1'b0);
    chk("lu1_pre", 0, 32'(a_stall), 32'd0);
    nxt();
    drive(1'b1, T_RT, 5'd8, 5'd9, 5'd10, 1'b0);
    chk("lu1_stall", 0, 32'(a_stall), 32'd1);
    chk("lu1_noflush", 0, 32'(a_if_flush), 32'd0);
    nxt();
    drive(1'b1, T_RT, 5'd8, 5'd9, 5'd10, 1'b0);
    chk("lu1_stall", 1, 32'(a_stall), 32'd0);
    chk("lu1_bubble", 1, 32'(a_ex), 32'd0);
    chk("lu1_memrd", 1, 32'(a_mem), 32'b1000);
    nxt();
    drive(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("lu1_cons_ex", 2, 32'(a_ex), 32'(EX_RT));
    nxt();
    do_reset();

    // Load-use with MEM_LAT=3: three stall cycles
    drive(1'b1, T_LW, 5'd1, 5'd8, 5'd0, 1'b0);
    nxt();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, T_RT, 5'd8, 5'd9, 5'd10, 1'b0);
      chk("lu3_stall", k, 32'(c_stall), 32'(k < 3));
      if (k >= 1) chk("lu3_bubble", k, 32'(c_ex), 32'd0);
      nxt();
    end
    drive(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("lu3_cons_ex", 0, 32'(c_ex), 32'(EX_RT));
    nxt();
    do_reset();

    // Load into $0 never stalls and never writes back
    drive(1'b1, T_LW, 5'd1, 5'd0, 5'd0, 1'b0);
    nxt();
    drive(1'b1, T_RT, 5'd0, 5'd0, 5'd5, 1'b0);
    chk("z_stall_a", 0, 32'(a_stall), 32'd0);
    chk("z_stall_c", 0, 32'(c_stall), 32'd0);
    nxt();
    drive(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    nxt();
    drive(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("z_wb_rw_a", 0, 32'(a_RegWrite), 32'd0);
    chk("z_wb_dst_a", 0, 32'(a_dst), 32'd0);
    chk("z_wb_rw_c", 0, 32'(c_RegWrite), 32'd0);
    chk("z_wb_dst_c", 0, 32'(c_dst), 32'd0);
    nxt();
    drive(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("z_cons_dst_a", 1, 32'(a_dst), 32'd5);
    nxt();
    do_reset();

    // Taken branch during an active stall (MEM_LAT=3)
    drive(1'b1, T_LW, 5'd1, 5'd8, 5'd0, 1'b0);
    nxt();
    drive(1'b1, T_RT, 5'd8, 5'd9, 5'd10, 1'b0);
    chk("br_stall_pre", 0, 32'(c_stall), 32'd1);
    nxt();
    drive(1'b1, T_RT, 5'd8, 5'd9, 5'd10, 1'b1);
    chk("br_stall", 1, 32'(c_stall), 32'd0);
    chk("br_flush", 1, 32'(c_if_flush), 32'd1);
    nxt();
    drive(1'b1, T_RT, 5'd8, 5'd9, 5'd10, 1'b0);
    chk("br_bubble", 2, 32'(c_ex), 32'd0);
    chk("br_run", 2, 32'(c_stall), 32'd0);
    chk("br_noflush", 2, 32'(c_if_flush), 32'd0);
    nxt();
    drive(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("br_cons_ex", 3, 32'(c_ex), 32'(EX_RT));
    nxt();
    do_reset();

    // jal flushes IF/ID and writes PC+8 into $31
    drive(1'b1, T_JAL, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("jal_flush", 0, 32'(a_if_flush), 32'd1);
    chk("jal_stall", 0, 32'(a_stall), 32'd0);
    nxt();
    drive(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("jal_ex", 1, 32'(a_ex), 32'(EX_JAL));
    chk("jal_noflush", 1, 32'(a_if_flush), 32'd0);
    nxt();
    drive(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    nxt();
    drive(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("jal_dst", 3, 32'(a_dst), 32'd31);
    chk("jal_rws", 3, 32'(a_RWS), 32'd1);
    chk("jal_rw", 3, 32'(a_RegWrite), 32'd1);
    nxt();
    do_reset();

    // Reset asserted in the second stall cycle (MEM_LAT=3)
    drive(1'b1, T_LW, 5'd1, 5'd8, 5'd0, 1'b0);
    nxt();
    drive(1'b1, T_RT, 5'd8, 5'd9, 5'd10, 1'b0);
    chk("rs_stall1", 0, 32'(c_stall), 32'd1);
    nxt();
    rst_n = 1'b0;
    drive(1'b1, T_RT, 5'd8, 5'd9, 5'd10, 1'b0);
    chk("rs_stall_held", 1, 32'(c_stall), 32'd0);
    chk("rs_flush_held", 1, 32'(c_if_flush), 32'd0);
    nxt();
    rst_n = 1'b1;
    drive(1'b1, T_RT, 5'd8, 5'd9, 5'd10, 1'b0);
    chk("rs_ex", 2, 32'(c_ex), 32'd0);
    chk("rs_mem", 2, 32'(c_mem), 32'd0);
    chk("rs_wb", 2, 32'(c_wb), 32'd0);
    chk("rs_dst", 2, 32'(c_dst), 32'd0);
    chk("rs_stall", 2, 32'(c_stall), 32'd0);
    nxt();
    drive(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("rs_resume_ex", 3, 32'(c_ex), 32'(EX_RT));
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
